// File: rtl/clock_enable_gen_if.sv
// Bundles the configuration inputs, run/step controls and tick/square/divisor outputs of
// clock_enable_gen. The master drives controls; the slave (the generator) drives the outputs.
interface clock_enable_gen_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int CH_W   = 2
);
   logic                    cfg_we;
   logic [CH_W-1:0]         cfg_sel;
   logic [CNT_W-1:0]        cfg_div;
   logic [NUM_CH-1:0]       ch_run;
   logic                    step_mode;
   logic                    step_req;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       square;
   logic [NUM_CH*CNT_W-1:0] div_q;

   modport master (
      output cfg_we, cfg_sel, cfg_div, ch_run, step_mode, step_req,
      input  tick, square, div_q
   );

   modport slave (
      input  cfg_we, cfg_sel, cfg_div, ch_run, step_mode, step_req,
      output tick, square, div_q
   );
endinterface

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator: per-channel divider producing a one-cycle
// tick and a 50% square wave, with a CPU single-step mode on channel STEP_CH.
module clock_enable_gen #(
   parameter int                      NUM_CH   = 4,
   parameter int                      CNT_W    = 16,
   parameter int                      CH_W     = 2,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd50000, 16'd50, 16'd2, 16'd1},
   parameter int                      STEP_CH  = 2
) (
   input  logic              clock,
   input  logic              reset,
   clock_enable_gen_if.slave bus
);
   typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FIRE} step_state_t;

   logic                    req_q_reg;
   logic                    step_rise;
   logic [NUM_CH-1:0]       tick_vec;
   logic [NUM_CH-1:0]       square_vec;
   logic [NUM_CH*CNT_W-1:0] div_vec;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_q_reg <= 1'b0;
      end else begin
         req_q_reg <= bus.step_req;
      end
   end

   assign step_rise = bus.step_req & ~req_q_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic [CNT_W-1:0] div_reg;
         logic             tick_reg;
         logic             tick_next;
         logic             square_reg;
         logic             toggle;
         logic             wr_hit;

         // Selects at or beyond NUM_CH never match any channel index.
         assign wr_hit = bus.cfg_we && (int'(bus.cfg_sel) == gi);

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               div_reg <= DIV_INIT[gi*CNT_W +: CNT_W];
            end else if (wr_hit) begin
               div_reg <= bus.cfg_div;
            end
         end

         // Free-running divider; a write restarts the period and overrides a coincident wrap.
         always_comb begin
            cnt_next  = cnt_reg;
            tick_next = 1'b0;
            toggle    = 1'b0;
            if (wr_hit) begin
               cnt_next = '0;
            end else if (bus.ch_run[gi]) begin
               if (div_reg == '0) begin
                  cnt_next = '0;
               end else if (cnt_reg == div_reg - CNT_W'(1)) begin
                  cnt_next  = '0;
                  tick_next = 1'b1;
                  toggle    = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end

         if (gi == STEP_CH) begin : g_step
            step_state_t state_reg;

            always_ff @(posedge clock or negedge reset) begin
               if (!reset) begin
                  state_reg  <= ST_RUN;
                  cnt_reg    <= '0;
                  tick_reg   <= 1'b0;
                  square_reg <= 1'b0;
               end else begin
                  case (state_reg)
                     ST_RUN: begin
                        if (bus.step_mode) begin
                           state_reg <= ST_HOLD;
                           cnt_reg   <= '0;
                           tick_reg  <= 1'b0;
                        end else begin
                           cnt_reg    <= cnt_next;
                           tick_reg   <= tick_next;
                           square_reg <= square_reg ^ toggle;
                        end
                     end
                     ST_HOLD: begin
                        cnt_reg  <= '0;
                        tick_reg <= 1'b0;
                        if (!bus.step_mode) begin
                           state_reg <= ST_RUN;
                        end else if (step_rise && bus.ch_run[gi]) begin
                           state_reg <= ST_FIRE;
                        end
                     end
                     ST_FIRE: begin
                        // The pulse always completes, even if step mode was just dropped.
                        cnt_reg    <= '0;
                        tick_reg   <= 1'b1;
                        square_reg <= ~square_reg;
                        state_reg  <= bus.step_mode ? ST_HOLD : ST_RUN;
                     end
                     default: begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                        tick_reg  <= 1'b0;
                     end
                  endcase
               end
            end
         end else begin : g_free
            always_ff @(posedge clock or negedge reset) begin
               if (!reset) begin
                  cnt_reg    <= '0;
                  tick_reg   <= 1'b0;
                  square_reg <= 1'b0;
               end else begin
                  cnt_reg    <= cnt_next;
                  tick_reg   <= tick_next;
                  square_reg <= square_reg ^ toggle;
               end
            end
         end

         assign tick_vec[gi]                  = tick_reg;
         assign square_vec[gi]                = square_reg;
         assign div_vec[gi*CNT_W +: CNT_W]    = div_reg;
      end
   endgenerate

   assign bus.tick   = tick_vec;
   assign bus.square = square_vec;
   assign bus.div_q  = div_vec;
endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomised bench for clock_enable_gen against a period/phase reference model.
module tb_clock_enable_gen;
   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 16;
   localparam int CH_W    = 2;
   localparam int STEP_CH = 2;
   localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd50000, 16'd50, 16'd2, 16'd1};

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   clock_enable_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

   clock_enable_gen #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DIV_INIT(DIV_INIT), .STEP_CH(STEP_CH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #10 clock = ~clock;

   // Model: pos counts enabled edges since the period reference; a tick lands when pos is a
   // multiple of D. square is the parity of the tick count.
   int m_div   [NUM_CH];
   int m_pos   [NUM_CH];
   int m_ticks [NUM_CH];
   bit m_tick  [NUM_CH];
   bit m_stepped;
   bit m_pending;
   bit m_prev_req;

   task automatic model_reset();
      logic [NUM_CH*CNT_W-1:0] init_v;
      init_v = DIV_INIT;
      for (int i = 0; i < NUM_CH; i++) begin
         m_div[i]   = int'(init_v[i*CNT_W +: CNT_W]);
         m_pos[i]   = 0;
         m_ticks[i] = 0;
         m_tick[i]  = 1'b0;
      end
      m_stepped  = 1'b0;
      m_pending  = 1'b0;
      m_prev_req = 1'b0;
   endtask

   task automatic model_edge();
      bit wr;
      for (int i = 0; i < NUM_CH; i++) begin
         wr = bus.cfg_we && (int'(bus.cfg_sel) == i);
         if (i == STEP_CH && (m_stepped || bus.step_mode)) begin
            if (!m_stepped) begin
               m_stepped = 1'b1;
               m_pos[i]  = 0;
               m_tick[i] = 1'b0;
            end else if (m_pending) begin
               m_pending = 1'b0;
               m_tick[i] = 1'b1;
               m_ticks[i]++;
               m_pos[i]  = 0;
               m_stepped = bus.step_mode;
            end else begin
               m_tick[i] = 1'b0;
               m_pos[i]  = 0;
               if (!bus.step_mode) m_stepped = 1'b0;
               else if (bus.step_req && !m_prev_req && bus.ch_run[i]) m_pending = 1'b1;
            end
         end else if (wr) begin
            m_pos[i]  = 0;
            m_tick[i] = 1'b0;
         end else if (!bus.ch_run[i]) begin
            m_tick[i] = 1'b0;
         end else if (m_div[i] == 0) begin
            m_pos[i]  = 0;
            m_tick[i] = 1'b0;
         end else begin
            m_pos[i]++;
            m_tick[i] = (m_pos[i] % m_div[i]) == 0;
            if (m_tick[i]) m_ticks[i]++;
         end
         if (wr) m_div[i] = int'(bus.cfg_div);
      end
      m_prev_req = bus.step_req;
   endtask

   function automatic logic [NUM_CH-1:0] exp_tick();
      logic [NUM_CH-1:0] r;
      for (int i = 0; i < NUM_CH; i++) r[i] = m_tick[i];
      return r;
   endfunction

   function automatic logic [NUM_CH-1:0] exp_sq();
      logic [NUM_CH-1:0] r;
      for (int i = 0; i < NUM_CH; i++) r[i] = (m_ticks[i] % 2) == 1;
      return r;
   endfunction

   function automatic logic [NUM_CH*CNT_W-1:0] exp_div();
      logic [NUM_CH*CNT_W-1:0] r;
      for (int i = 0; i < NUM_CH; i++) r[i*CNT_W +: CNT_W] = CNT_W'(m_div[i]);
      return r;
   endfunction

   // One clock edge: the model sees the same inputs the DUT samples; outputs read at negedge.
   task automatic advance();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic cfg_write(input int sel, input int d);
      bus.cfg_we  = 1'b1;
      bus.cfg_sel = CH_W'(sel);
      bus.cfg_div = CNT_W'(d);
      advance();
      bus.cfg_we  = 1'b0;
   endtask

   task automatic test_reset();
      bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_div = '0;
      bus.ch_run = '1; bus.step_mode = 1'b0; bus.step_req = 1'b0;
      #5 reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      checks++;
      if (bus.tick !== '0) begin
         errors++; $display("FAIL reset_tick: got %b want 0", bus.tick);
      end
      checks++;
      if (bus.square !== '0) begin
         errors++; $display("FAIL reset_square: got %b want 0", bus.square);
      end
      checks++;
      if (bus.div_q !== DIV_INIT) begin
         errors++; $display("FAIL reset_div_q: got %h want %h", bus.div_q, DIV_INIT);
      end
      reset = 1'b1;
   endtask

   task automatic test_defaults();
      int first3 = -1;
      int count2 = 0;
      for (int e = 1; e <= 50000; e++) begin
         advance();
         checks++;
         if ({bus.tick, bus.square, bus.div_q} !== {exp_tick(), exp_sq(), exp_div()}) begin
            errors++;
            $display("FAIL defaults edge %0d: tick=%b sq=%b div_q=%h want tick=%b sq=%b div_q=%h",
                     e, bus.tick, bus.square, bus.div_q, exp_tick(), exp_sq(), exp_div());
         end
         if (bus.tick[3] && first3 < 0) first3 = e;
         if (bus.tick[2]) count2++;
         if (e == 50 || e == 100) begin
            checks++;
            if (bus.square[2] !== (e == 50)) begin
               errors++; $display("FAIL square2_period edge %0d: got %b want %b", e, bus.square[2], e == 50);
            end
         end
      end
      checks++;
      if (first3 != 50000) begin
         errors++; $display("FAIL tick3_first: got edge %0d want 50000", first3);
      end
      checks++;
      if (count2 != 1000) begin
         errors++; $display("FAIL tick2_count: got %0d want 1000", count2);
      end
   endtask

   task automatic test_cfg_write();
      int found = 0;
      int mask  = 0;
      for (int k = 0; k < 60 && found == 0; k++) begin
         if (((m_pos[2] + 1) % m_div[2]) == 0) found = 1;
         else advance();
      end
      checks++;
      if (found == 0) begin
         errors++; $display("FAIL cfg_wrap_search: got no wrap within 60 cycles want one");
      end
      cfg_write(2, 5);
      checks++;
      if (bus.tick[2] !== 1'b0) begin
         errors++; $display("FAIL cfg_write_beats_wrap: tick2 got %b want 0", bus.tick[2]);
      end
      checks++;
      if (bus.div_q[47:32] !== 16'd5) begin
         errors++; $display("FAIL cfg_div_q: got %0d want 5", bus.div_q[47:32]);
      end
      for (int e = 1; e <= 10; e++) begin
         advance();
         if (bus.tick[2]) mask |= (1 << e);
      end
      checks++;
      if (mask != ((1 << 5) | (1 << 10))) begin
         errors++; $display("FAIL cfg_new_period: tick edges mask %h want %h", mask, (1 << 5) | (1 << 10));
      end
      for (int c = 0; c < 400; c++) begin
         bus.cfg_we  = ($urandom_range(0, 7) == 0);
         bus.cfg_sel = CH_W'($urandom_range(0, NUM_CH - 1));
         bus.cfg_div = CNT_W'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) bus.ch_run = NUM_CH'($urandom);
         advance();
         checks++;
         if ({bus.tick, bus.square, bus.div_q} !== {exp_tick(), exp_sq(), exp_div()}) begin
            errors++;
            $display("FAIL cfg_random cycle %0d: tick=%b sq=%b div_q=%h want tick=%b sq=%b div_q=%h",
                     c, bus.tick, bus.square, bus.div_q, exp_tick(), exp_sq(), exp_div());
         end
      end
      bus.cfg_we = 1'b0;
      bus.ch_run = '1;
   endtask

   task automatic test_div_zero();
      logic sq1;
      int   cnt = 0;
      int   first = -1;
      cfg_write(1, 0);
      sq1 = bus.square[1];
      for (int e = 1; e <= 20; e++) begin
         advance();
         checks++;
         if (bus.tick[1] !== 1'b0 || bus.square[1] !== sq1 || bus.tick !== exp_tick()) begin
            errors++;
            $display("FAIL div_zero edge %0d: tick=%b sq1=%b want tick=%b sq1=%b",
                     e, bus.tick, bus.square[1], exp_tick(), sq1);
         end
      end
      cfg_write(1, 3);
      for (int e = 1; e <= 30; e++) begin
         advance();
         if (bus.tick[1]) begin
            cnt++;
            if (first < 0) first = e;
         end
      end
      checks++;
      if (cnt != 10 || first != 3) begin
         errors++; $display("FAIL div_three: got %0d ticks first at %0d want 10 first at 3", cnt, first);
      end
   endtask

   task automatic test_step();
      int pulses;
      int offset;
      bus.step_mode = 1'b1;
      repeat (5) advance();
      for (int k = 0; k < 3; k++) begin
         pulses = 0;
         offset = -1;
         bus.step_req = 1'b1;
         for (int e = 1; e <= 10; e++) begin
            advance();
            if (e == 3) bus.step_req = 1'b0;
            if (bus.tick[2]) begin
               pulses++;
               offset = e;
            end
         end
         checks++;
         if (pulses != 1 || offset != 2) begin
            errors++; $display("FAIL step_pulse %0d: got %0d pulses at %0d want 1 at 2", k, pulses, offset);
         end
      end
      pulses = 0;
      bus.step_req = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         advance();
         if (bus.tick[2]) pulses++;
      end
      bus.step_req = 1'b0;
      checks++;
      if (pulses != 1) begin
         errors++; $display("FAIL step_held: got %0d pulses want 1", pulses);
      end
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) bus.step_req = ~bus.step_req;
         if ($urandom_range(0, 29) == 0) bus.step_mode = ~bus.step_mode;
         bus.ch_run[2] = ($urandom_range(0, 9) != 0);
         advance();
         checks++;
         if ({bus.tick, bus.square} !== {exp_tick(), exp_sq()}) begin
            errors++;
            $display("FAIL step_random cycle %0d: tick=%b sq=%b want tick=%b sq=%b",
                     c, bus.tick, bus.square, exp_tick(), exp_sq());
         end
      end
      bus.step_mode = 1'b0;
      bus.step_req  = 1'b0;
      bus.ch_run    = '1;
      repeat (3) advance();
   endtask

   task automatic test_run_pause();
      int first = -1;
      cfg_write(1, 5);
      for (int e = 1; e <= 12; e++) begin
         bus.ch_run[1] = !(e >= 3 && e <= 9);
         advance();
         checks++;
         if (bus.tick !== exp_tick() || bus.square !== exp_sq()) begin
            errors++;
            $display("FAIL run_pause edge %0d: tick=%b sq=%b want tick=%b sq=%b",
                     e, bus.tick, bus.square, exp_tick(), exp_sq());
         end
         if (bus.tick[1] && first < 0) first = e;
      end
      checks++;
      if (first != 12) begin
         errors++; $display("FAIL run_resume_phase: first tick1 at %0d want 12", first);
      end
   endtask

   task automatic test_async_reset();
      int first2 = -1;
      bus.ch_run    = '1;
      bus.step_mode = 1'b1;
      repeat (3) advance();
      bus.step_req = 1'b1;
      @(posedge clock);
      model_edge();
      #3 reset = 1'b0;
      #1;
      checks++;
      if (bus.tick !== '0 || bus.square !== '0 || bus.div_q !== DIV_INIT) begin
         errors++;
         $display("FAIL async_reset_fire: tick=%b sq=%b div_q=%h want 0 0 %h",
                  bus.tick, bus.square, bus.div_q, DIV_INIT);
      end
      model_reset();
      bus.step_mode = 1'b0;
      bus.step_req  = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      for (int e = 1; e <= 120; e++) begin
         advance();
         checks++;
         if ({bus.tick, bus.square, bus.div_q} !== {exp_tick(), exp_sq(), exp_div()}) begin
            errors++;
            $display("FAIL after_reset edge %0d: tick=%b sq=%b want tick=%b sq=%b",
                     e, bus.tick, bus.square, exp_tick(), exp_sq());
         end
         if (bus.tick[2] && first2 < 0) first2 = e;
      end
      checks++;
      if (first2 != 50) begin
         errors++; $display("FAIL after_reset_tick2: first at %0d want 50", first2);
      end
      repeat (37) advance();
      #($urandom_range(1, 8));
      reset = 1'b0;
      #1;
      checks++;
      if (bus.tick !== '0 || bus.square !== '0 || bus.div_q !== DIV_INIT) begin
         errors++;
         $display("FAIL async_reset_mid: tick=%b sq=%b div_q=%h want 0 0 %h",
                  bus.tick, bus.square, bus.div_q, DIV_INIT);
      end
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      for (int e = 1; e <= 60; e++) begin
         advance();
         checks++;
         if ({bus.tick, bus.square} !== {exp_tick(), exp_sq()}) begin
            errors++;
            $display("FAIL after_mid_reset edge %0d: tick=%b sq=%b want tick=%b sq=%b",
                     e, bus.tick, bus.square, exp_tick(), exp_sq());
         end
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_cfg_write();
      test_div_zero();
      test_step();
      test_run_pause();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
